fifo_param: RTL and testbench

- Parametrised successor of the team's 2-entry, 2-bit synchronous FIFO.
- Provides configurable data width and power-of-two depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Single clock domain; used as the standard elastic buffer between streaming pipeline stages.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ptr.sv | 26 ++
 rtl/fifo_param.sv | 106 ++++++++++
 tb/tb_fifo_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: depth math and parameter legality.
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int depth_of(input int depth_log2);
    return 1 << depth_log2;
  endfunction

  // Thresholds must be reachable by a count of 0..depth.
  function automatic bit params_ok(input int data_width, input int depth_log2,
                                   input int afull_thresh, input int aempty_thresh);
    return (data_width >= 1) && (depth_log2 >= 1) &&
           (clog2(depth_of(depth_log2)) == depth_log2) &&
           (afull_thresh >= 1) && (afull_thresh <= depth_of(depth_log2)) &&
           (aempty_thresh >= 0) && (aempty_thresh <= depth_of(depth_log2) - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer; the extra MSB distinguishes full from empty.
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with first-word fall-through output, occupancy flags, flush
// and sticky overflow/underflow errors.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH_LOG2    = 2,
  parameter int AFULL_THRESH  = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_push,
  input  logic                  io_pop,
  input  logic                  io_flush,
  input  logic                  io_clr_err,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_empty,
  output logic                  io_full,
  output logic                  io_afull,
  output logic                  io_aempty,
  output logic [DEPTH_LOG2:0]   io_count,
  output logic                  io_overflow,
  output logic                  io_underflow
);

  localparam int DEPTH = depth_of(DEPTH_LOG2);
  localparam int W     = DEPTH_LOG2 + 1;
  localparam logic [W-1:0] LP_AFULL  = W'(AFULL_THRESH);
  localparam logic [W-1:0] LP_AEMPTY = W'(AEMPTY_THRESH);

  if (!params_ok(DATA_WIDTH, DEPTH_LOG2, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("fifo_param: illegal DATA_WIDTH/DEPTH_LOG2/AFULL_THRESH/AEMPTY_THRESH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [W-1:0]          w_rd_ptr;
  logic [W-1:0]          w_wr_ptr;
  logic [W-1:0]          w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  r_overflow;
  logic                  r_underflow;

  assign w_empty   = (w_wr_ptr == w_rd_ptr);
  assign w_full    = (w_wr_ptr[W-2:0] == w_rd_ptr[W-2:0]) &&
                     (w_wr_ptr[W-1] != w_rd_ptr[W-1]);
  assign w_count   = w_wr_ptr - w_rd_ptr;
  // Flush wins over both requests: nothing is written and neither pointer moves.
  assign w_push_ok = io_push & ~w_full & ~io_flush;
  assign w_pop_ok  = io_pop & ~w_empty & ~io_flush;

  fifo_ptr #(.W(W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_push_ok),
    .clr   (io_flush),
    .ptr   (w_wr_ptr)
  );

  fifo_ptr #(.W(W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pop_ok),
    .clr   (io_flush),
    .ptr   (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_ptr[W-2:0]] <= io_din;
    end
  end

  // Set has priority over clear so a coinciding fault is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (io_push & w_full & ~io_flush) begin
        r_overflow <= 1'b1;
      end else if (io_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (io_pop & w_empty & ~io_flush) begin
        r_underflow <= 1'b1;
      end else if (io_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign io_dout      = r_mem[w_rd_ptr[W-2:0]];
  assign io_empty     = w_empty;
  assign io_full      = w_full;
  assign io_afull     = (w_count >= LP_AFULL);
  assign io_aempty    = (w_count <= LP_AEMPTY);
  assign io_count     = w_count;
  assign io_overflow  = r_overflow;
  assign io_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed, table-driven bench for fifo_param at default parameters (depth 4).
module tb_fifo_param;

  logic       clk;
  logic       reset;
  logic [7:0] io_din;
  logic       io_push;
  logic       io_pop;
  logic       io_flush;
  logic       io_clr_err;
  logic [7:0] io_dout;
  logic       io_empty;
  logic       io_full;
  logic       io_afull;
  logic       io_aempty;
  logic [2:0] io_count;
  logic       io_overflow;
  logic       io_underflow;

  int checks = 0;
  int errors = 0;

  fifo_param dut (
    .clk          (clk),
    .reset        (reset),
    .io_din       (io_din),
    .io_push      (io_push),
    .io_pop       (io_pop),
    .io_flush     (io_flush),
    .io_clr_err   (io_clr_err),
    .io_dout      (io_dout),
    .io_empty     (io_empty),
    .io_full      (io_full),
    .io_afull     (io_afull),
    .io_aempty    (io_aempty),
    .io_count     (io_count),
    .io_overflow  (io_overflow),
    .io_underflow (io_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       flush;
    logic       clr;
    logic [7:0] din;
    int         cnt;
    logic       ovf;
    logic       unf;
    logic       chk_dout;
    logic [7:0] dout;
  } vec_t;

  vec_t tab_a[12];
  vec_t tab_b[10];

  function automatic vec_t mk(input logic pu, input logic po, input logic fl, input logic cl,
                              input logic [7:0] din, input int cnt, input logic ovf,
                              input logic unf, input logic chk, input logic [7:0] dout);
    vec_t v;
    v.push = pu; v.pop = po; v.flush = fl; v.clr = cl; v.din = din;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.chk_dout = chk; v.dout = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags are derived from the expected count using depth 4, afull>=3, aempty<=1.
  task automatic check_state(input string tag, input int cnt, input logic ovf, input logic unf);
    check({tag, ".count"},  32'(io_count),     32'(cnt));
    check({tag, ".empty"},  32'(io_empty),     32'(cnt == 0));
    check({tag, ".full"},   32'(io_full),      32'(cnt == 4));
    check({tag, ".afull"},  32'(io_afull),     32'(cnt >= 3));
    check({tag, ".aempty"}, 32'(io_aempty),    32'(cnt <= 1));
    check({tag, ".ovf"},    32'(io_overflow),  32'(ovf));
    check({tag, ".unf"},    32'(io_underflow), 32'(unf));
  endtask

  task automatic drive(input logic pu, input logic po, input logic fl, input logic cl,
                       input logic [7:0] din);
    io_push = pu; io_pop = po; io_flush = fl; io_clr_err = cl; io_din = din;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.push, v.pop, v.flush, v.clr, v.din);
    @(posedge clk);
    #1;
    check_state(tag, v.cnt, v.ovf, v.unf);
    if (v.chk_dout) check({tag, ".dout"}, 32'(io_dout), 32'(v.dout));
  endtask

  logic [7:0] q[$];

  initial begin
    //            push pop fl clr din    cnt ovf unf chk dout
    tab_a[0]  = mk(1, 0, 0, 0, 8'h11, 1, 0, 0, 1, 8'h11);
    tab_a[1]  = mk(1, 0, 0, 0, 8'h22, 2, 0, 0, 1, 8'h11);
    tab_a[2]  = mk(1, 0, 0, 0, 8'h33, 3, 0, 0, 1, 8'h11);
    tab_a[3]  = mk(1, 0, 0, 0, 8'h44, 4, 0, 0, 1, 8'h11);
    tab_a[4]  = mk(1, 0, 0, 0, 8'h55, 4, 1, 0, 1, 8'h11);
    tab_a[5]  = mk(0, 1, 0, 0, 8'h00, 3, 1, 0, 1, 8'h22);
    tab_a[6]  = mk(0, 1, 0, 0, 8'h00, 2, 1, 0, 1, 8'h33);
    tab_a[7]  = mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 1, 8'h44);
    tab_a[8]  = mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    tab_a[9]  = mk(1, 1, 0, 0, 8'hA5, 1, 1, 1, 1, 8'hA5);
    tab_a[10] = mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 1, 8'hA5);
    tab_a[11] = mk(1, 0, 0, 0, 8'h01, 2, 0, 0, 1, 8'hA5);

    tab_b[0]  = mk(1, 0, 0, 0, 8'h5A, 3, 0, 0, 1, 8'h18);
    tab_b[1]  = mk(1, 0, 1, 0, 8'h66, 0, 0, 0, 0, 8'h00);
    tab_b[2]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    tab_b[3]  = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    tab_b[4]  = mk(0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    tab_b[5]  = mk(1, 0, 0, 0, 8'h77, 1, 0, 1, 1, 8'h77);
    tab_b[6]  = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    tab_b[7]  = mk(1, 0, 0, 0, 8'h81, 1, 0, 1, 1, 8'h81);
    tab_b[8]  = mk(1, 0, 0, 0, 8'h82, 2, 0, 1, 1, 8'h81);
    tab_b[9]  = mk(1, 0, 0, 0, 8'h83, 3, 0, 1, 1, 8'h81);

    reset = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_state("reset", 0, 0, 0);
    reset = 1'b1;

    foreach (tab_a[i]) apply(tab_a[i], $sformatf("a%0d", i));

    // Steady push+pop at two entries; pointers wrap twice without a false flag.
    q.push_back(8'hA5);
    q.push_back(8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 8'(8'h10 + i));
      @(posedge clk);
      #1;
      void'(q.pop_front());
      q.push_back(8'(8'h10 + i));
      check_state($sformatf("stream%0d", i), 2, 0, 0);
      check($sformatf("stream%0d.dout", i), 32'(io_dout), 32'(q[0]));
    end

    foreach (tab_b[i]) apply(tab_b[i], $sformatf("b%0d", i));

    // Asynchronous reset with three entries held: must clear before any clock edge.
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    apply(mk(1, 0, 0, 0, 8'h88, 1, 0, 0, 1, 8'h88), "post_rst_push");
    apply(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00), "post_rst_pop");

    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
